ring_osc_sequencer: RTL and testbench

- Digital controller that sequences a bank of enable-gated ring oscillators.
- Per measurement it enables one selected ring, waits a settle interval, then counts that ring's rising edges over a programmable gate window of clk cycles.
- It presents the count through a valid/ready handshake and then disables the ring.
- It sits between the user input pins and the ring enables. Ring outputs, each divided to below clk/4 by the ring's own divider, come back to it as ring_in.

---
 rtl/ring_osc_sequencer.sv | 133 +++++++++++++
 tb/tb_ring_osc_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ring_osc_sequencer.sv
// Sequences a bank of enable-gated ring oscillators: enable one ring, let it settle,
// count its synchronised rising edges over a gate window, then hand the count out.
module ring_osc_sequencer #(
    parameter int NUM_RINGS = 2,
    parameter int SEL_W     = 1,
    parameter int GATE_W    = 16,
    parameter int CNT_W     = 16,
    parameter int SETTLE    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [SEL_W-1:0]     ring_sel,
    input  logic [GATE_W-1:0]    gate_cycles,
    output logic [NUM_RINGS-1:0] ring_en,
    input  logic [NUM_RINGS-1:0] ring_in,
    output logic                 busy,
    output logic [CNT_W-1:0]     count,
    output logic                 overflow,
    output logic                 sel_err,
    output logic                 count_valid,
    input  logic                 count_ready
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SETTLE  = 2'd1;
    localparam logic [1:0] ST_MEASURE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam int SEL_N = 1 << SEL_W;
    localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    // Bit i set when ring index i exists; lets a select be validated by lookup.
    localparam logic [SEL_N-1:0] SEL_OK = SEL_N'((64'd1 << NUM_RINGS) - 64'd1);

    logic [1:0]           state;
    logic [SET_W-1:0]     settle_cnt;
    logic [GATE_W-1:0]    gate_cnt;
    logic [NUM_RINGS-1:0] sync_p0, sync_p1, sync_p2;
    logic [NUM_RINGS-1:0] edges;
    logic                 hit;
    logic [CNT_W:0]       inc;

    // Returns {saturated, next_value}; the value holds at all-ones.
    function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) return {1'b1, v};
        else    return {1'b0, v + CNT_W'(1)};
    endfunction

    // Stage p0/p1: two-flop synchroniser; stage p2: previous value for edge detect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            sync_p2 <= '0;
        end else begin
            sync_p0 <= ring_in;
            sync_p1 <= sync_p0;
            sync_p2 <= sync_p1;
        end
    end

    assign edges = sync_p1 & ~sync_p2;
    // ring_en is the latched one-hot select, so it doubles as the edge mask.
    assign hit   = |(edges & ring_en);
    assign inc   = sat_inc(count);
    assign busy  = (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            ring_en     <= '0;
            count       <= '0;
            overflow    <= 1'b0;
            sel_err     <= 1'b0;
            count_valid <= 1'b0;
            settle_cnt  <= '0;
            gate_cnt    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        count    <= '0;
                        overflow <= 1'b0;
                        if (SEL_OK[ring_sel]) begin
                            sel_err    <= 1'b0;
                            ring_en    <= NUM_RINGS'(1) << ring_sel;
                            settle_cnt <= SET_W'(SETTLE - 1);
                            gate_cnt   <= gate_cycles;
                            state      <= ST_SETTLE;
                        end else begin
                            sel_err     <= 1'b1;
                            count_valid <= 1'b1;
                            state       <= ST_DONE;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt == '0) begin
                        if (gate_cnt == '0) begin
                            ring_en     <= '0;
                            count_valid <= 1'b1;
                            state       <= ST_DONE;
                        end else begin
                            state <= ST_MEASURE;
                        end
                    end else begin
                        settle_cnt <= settle_cnt - SET_W'(1);
                    end
                end
                ST_MEASURE: begin
                    if (hit) begin
                        count <= inc[CNT_W-1:0];
                        if (inc[CNT_W]) overflow <= 1'b1;
                    end
                    gate_cnt <= gate_cnt - GATE_W'(1);
                    if (gate_cnt == GATE_W'(1)) begin
                        ring_en     <= '0;
                        count_valid <= 1'b1;
                        state       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (count_ready) begin
                        count_valid <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ring_osc_sequencer.sv
// Bench for ring_osc_sequencer: clk-aligned ring models, expected results queued at
// start and compared when the result is handed out.
module tb_ring_osc_sequencer;

    localparam int TB_SETTLE = 8;

    typedef struct {
        logic [15:0] cnt;
        logic        ovf;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  ring_sel;
    logic [15:0] gate_cycles;
    logic [1:0]  ring_en;
    logic [1:0]  ring_in;
    logic        busy;
    logic [15:0] count;
    logic        overflow;
    logic        sel_err;
    logic        count_valid;
    logic        count_ready;

    logic        o_start;
    logic [1:0]  o_sel;
    logic [15:0] o_gate;
    logic [1:0]  o_en;
    logic        o_busy;
    logic [3:0]  o_count;
    logic        o_ovf;
    logic        o_err;
    logic        o_valid;
    logic        o_ready;

    int   n_run;
    int   n_fail;
    exp_t sb[$];
    int   per[2];
    int   ph[2];

    ring_osc_sequencer #(.NUM_RINGS(2), .SEL_W(2), .GATE_W(16), .CNT_W(16), .SETTLE(TB_SETTLE)) dut (
        .clk(clk), .rst(rst), .start(start), .ring_sel(ring_sel), .gate_cycles(gate_cycles),
        .ring_en(ring_en), .ring_in(ring_in), .busy(busy), .count(count), .overflow(overflow),
        .sel_err(sel_err), .count_valid(count_valid), .count_ready(count_ready)
    );

    ring_osc_sequencer #(.NUM_RINGS(2), .SEL_W(2), .GATE_W(16), .CNT_W(4), .SETTLE(TB_SETTLE)) dut_ovf (
        .clk(clk), .rst(rst), .start(o_start), .ring_sel(o_sel), .gate_cycles(o_gate),
        .ring_en(o_en), .ring_in(ring_in), .busy(o_busy), .count(o_count), .overflow(o_ovf),
        .sel_err(o_err), .count_valid(o_valid), .count_ready(o_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Square-wave ring models, high for the first half of each period.
    initial begin
        ring_in = 2'b00;
        forever begin
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                if (per[i] == 0) ring_in[i] = 1'b0;
                else begin
                    ph[i] = (ph[i] + 1) % per[i];
                    ring_in[i] = (ph[i] < per[i] / 2);
                end
            end
        end
    end

    task automatic set_rings(input int p0, input int p1);
        per[0] = p0; per[1] = p1; ph[0] = 0; ph[1] = 0;
    endtask

    // Entered and left at #1 after a rising edge.
    task automatic measure(input logic [1:0] sel, input int gate, input logic [15:0] ecnt,
                           input logic eovf, input logic eerr, input int hold,
                           input bit pulse, input bit early_rdy, input bit rdy_start);
        int k;
        bit en_ok;
        bit stable_ok;
        logic [1:0] en_exp;
        int exp_cyc;
        exp_t e;
        en_exp  = eerr ? 2'b00 : (2'b01 << sel);
        exp_cyc = eerr ? 1 : TB_SETTLE + gate + 1;
        e.cnt = ecnt; e.ovf = eovf; e.err = eerr;
        sb.push_back(e);
        start = 1'b1; ring_sel = sel; gate_cycles = 16'(gate); count_ready = early_rdy;
        @(posedge clk); #1;
        start = 1'b0; ring_sel = ~sel; gate_cycles = 16'd3;
        k = 1; en_ok = 1'b1;
        while (!count_valid && k < 1000) begin
            if (ring_en !== en_exp) en_ok = 1'b0;
            start = (pulse && k == 12);
            @(posedge clk); #1;
            k++;
        end
        start = 1'b0;
        check_eq("valid_cycle", 32'(k), 32'(exp_cyc));
        check_eq("en_window", 32'(en_ok), 32'd1);
        check_eq("en_off_done", 32'(ring_en), 32'd0);
        check_eq("busy_done", 32'(busy), 32'd1);
        stable_ok = 1'b1;
        for (int h = 0; h < hold; h++) begin
            if (!(count_valid === 1'b1 && count === ecnt && overflow === eovf && sel_err === eerr))
                stable_ok = 1'b0;
            start = (h == 3); ring_sel = 2'd1; gate_cycles = 16'd5;
            @(posedge clk); #1;
        end
        start = rdy_start;
        check_eq("hold_stable", 32'(stable_ok), 32'd1);
        count_ready = 1'b1;
        check_eq("sb_has_entry", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check_eq("result_count", 32'(count), 32'(e.cnt));
            check_eq("result_ovf", 32'(overflow), 32'(e.ovf));
            check_eq("result_err", 32'(sel_err), 32'(e.err));
        end
        @(posedge clk); #1;
        count_ready = 1'b0; start = 1'b0;
        check_eq("idle_busy", 32'(busy), 32'd0);
        check_eq("idle_valid", 32'(count_valid), 32'd0);
        check_eq("count_kept", 32'(count), 32'(e.cnt));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        bit quiet;
        n_run = 0; n_fail = 0;
        set_rings(0, 0);
        rst = 1'b1; start = 1'b0; ring_sel = 2'd0; gate_cycles = 16'd0; count_ready = 1'b0;
        o_start = 1'b0; o_sel = 2'd0; o_gate = 16'd0; o_ready = 1'b0;
        repeat (3) @(posedge clk); #1;
        check_eq("rst_ring_en", 32'(ring_en), 32'd0);
        check_eq("rst_count", 32'(count), 32'd0);
        check_eq("rst_ovf", 32'(overflow), 32'd0);
        check_eq("rst_sel_err", 32'(sel_err), 32'd0);
        check_eq("rst_valid", 32'(count_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic count, with a start pulse mid-measurement that must be ignored
        set_rings(8, 0);
        measure(2'd0, 64, 16'd8, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;

        // Selection isolation, back-to-back, long hold with start pulse while in DONE
        set_rings(16, 4);
        measure(2'd1, 64, 16'd16, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        measure(2'd0, 64, 16'd4, 1'b0, 1'b0, 20, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        check_eq("no_queued_start", 32'(busy), 32'd0);

        // Zero gate with ready held high beforehand
        measure(2'd1, 0, 16'd0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1;

        // Bad select, handshake coinciding with start
        measure(2'd2, 64, 16'd0, 1'b0, 1'b1, 2, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        check_eq("start_with_ready_ignored", 32'(busy), 32'd0);

        // Saturation on the 4-bit counter instance
        set_rings(4, 0);
        o_start = 1'b1; o_sel = 2'd0; o_gate = 16'd128;
        @(posedge clk); #1;
        o_start = 1'b0;
        k = 1;
        while (!o_valid && k < 1000) begin @(posedge clk); #1; k++; end
        check_eq("ovf_valid_cycle", 32'(k), 32'(TB_SETTLE + 129));
        check_eq("ovf_count", 32'(o_count), 32'd15);
        check_eq("ovf_flag", 32'(o_ovf), 32'd1);
        o_ready = 1'b1;
        @(posedge clk); #1;
        o_ready = 1'b0;
        check_eq("ovf_idle", 32'(o_busy), 32'd0);

        // Reset in the middle of MEASURE
        set_rings(8, 0);
        start = 1'b1; ring_sel = 2'd0; gate_cycles = 16'd64;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) @(posedge clk); #1;
        check_eq("rst_pre_en", 32'(ring_en), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("rst_async_en", 32'(ring_en), 32'd0);
        check_eq("rst_async_busy", 32'(busy), 32'd0);
        @(posedge clk); #3;
        rst = 1'b0;
        quiet = 1'b1;
        repeat (100) begin
            @(posedge clk); #1;
            if (count_valid !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
        end
        check_eq("rst_no_result", 32'(quiet), 32'd1);

        // Recovery after abort
        set_rings(16, 4);
        measure(2'd0, 64, 16'd4, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        check_eq("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
